seven_seg_scan_driver: RTL and testbench

Parametrised, time-multiplexed N-digit seven-segment driver and the successor to our two-digit combinational hex display block. It accepts a binary value through a valid/ready load handshake and displays it in hex or decimal. Decimal values are converted by a sequential double-dabble engine. The digits are scanned one at a time onto a shared segment bus, with optional leading-zero blanking and per-digit decimal points.

---
 rtl/seven_seg_scan_driver_pkg.sv | 24 ++
 rtl/seven_seg_scan_driver_if.sv | 22 ++
 rtl/seven_seg_scan_driver_bin2bcd_seq.sv | 65 ++++++
 rtl/seven_seg_scan_driver.sv | 161 ++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants and types for the scanned seven-segment display driver.
// Segment bytes are active-high: bit7 = dp, bits 6..0 = g..a.
package seven_seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;

    // Entry n is the glyph for hex digit n.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic [7:0] hex2seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Load handshake bundle: a value plus its display attributes, valid/ready.
interface seven_seg_scan_driver_if #(
    parameter int DATA_W     = 16,
    parameter int NUM_DIGITS = 4
);
    logic                  load_valid;
    logic                  load_ready;
    logic [DATA_W-1:0]     value;
    logic                  dec_mode;
    logic                  blank_lz;
    logic [NUM_DIGITS-1:0] dp_in;

    modport master (
        output load_valid, value, dec_mode, blank_lz, dp_in,
        input  load_ready
    );

    modport slave (
        input  load_valid, value, dec_mode, blank_lz, dp_in,
        output load_ready
    );
endinterface

// File: rtl/seven_seg_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle for DATA_W cycles.
// o_ovf flags any bit shifted out of the top digit, i.e. value >= 10^NUM_DIGITS.
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic [DATA_W-1:0]          i_value,
    output logic                       o_done,
    output logic [NUM_DIGITS-1:0][3:0] o_bcd,
    output logic                       o_ovf
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]          r_bin;
    logic [NUM_DIGITS-1:0][3:0] r_bcd;
    logic [NUM_DIGITS-1:0][3:0] w_adj;
    logic [4*NUM_DIGITS-1:0]    w_adj_flat;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_busy;
    logic                       r_ovf;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[i] >= 4'd5) w_adj[i] = r_bcd[i] + 4'd3;
        end
    end

    assign w_adj_flat = w_adj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (i_start) begin
            r_bin  <= i_value;
            r_bcd  <= '0;
            r_cnt  <= CNT_W'(DATA_W);
            r_busy <= 1'b1;
            r_ovf  <= 1'b0;
        end else if (r_busy) begin
            r_bcd <= {w_adj_flat[4*NUM_DIGITS-2:0], r_bin[DATA_W-1]};
            r_ovf <= r_ovf | w_adj_flat[4*NUM_DIGITS-1];
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
        end
    end

    // High during the final step so the caller can leave its wait state on the
    // same edge that produces the finished result.
    assign o_done = r_busy && (r_cnt == CNT_W'(1));
    assign o_bcd  = r_bcd;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver: hex or decimal display of a
// loaded value, leading-zero blanking, per-digit decimal points.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 16,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_seg_scan_driver_if.slave ld,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  overflow
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    state_t r_state, w_state_nxt;
    logic   w_load_ready;
    logic   w_accept;

    logic [DATA_W-1:0]     r_cap_val;
    logic                  r_cap_dec;
    logic                  r_cap_blz;
    logic [NUM_DIGITS-1:0] r_cap_dp;
    logic [4*NUM_DIGITS-1:0] w_hex_flat;

    logic                       w_conv_done;
    logic [NUM_DIGITS-1:0][3:0] w_bcd;
    logic                       w_bcd_ovf;

    logic [NUM_DIGITS-1:0][3:0] r_disp;
    logic                       r_disp_blz;
    logic [NUM_DIGITS-1:0]      r_disp_dp;
    logic                       r_ovf;

    logic [NUM_DIGITS-1:0]      w_blank;
    logic [NUM_DIGITS-1:0][7:0] w_seg;

    logic [PRE_W-1:0]      r_pre;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_wrap;
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig_en;

    // ---------------- load FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (ld.load_valid) w_state_nxt = ld.dec_mode ? CONV : COMMIT;
            CONV:    if (w_conv_done)   w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_load_ready = (r_state == IDLE);
    end

    assign ld.load_ready = w_load_ready;
    assign w_accept      = ld.load_valid && w_load_ready;

    // ---------------- capture / conversion / commit ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_val <= '0;
            r_cap_dec <= 1'b0;
            r_cap_blz <= 1'b1;
            r_cap_dp  <= '0;
        end else if (w_accept) begin
            r_cap_val <= ld.value;
            r_cap_dec <= ld.dec_mode;
            r_cap_blz <= ld.blank_lz;
            r_cap_dp  <= ld.dp_in;
        end
    end

    always_comb begin
        w_hex_flat               = '0;
        w_hex_flat[DATA_W-1:0]   = r_cap_val;
    end

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept && ld.dec_mode),
        .i_value (ld.value),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd),
        .o_ovf   (w_bcd_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp     <= '0;
            r_disp_blz <= 1'b1;
            r_disp_dp  <= '0;
            r_ovf      <= 1'b0;
        end else if (r_state == COMMIT) begin
            r_disp     <= r_cap_dec ? w_bcd : w_hex_flat;
            r_disp_blz <= r_cap_blz;
            r_disp_dp  <= r_cap_dp;
            r_ovf      <= r_cap_dec && w_bcd_ovf;
        end
    end

    // ---------------- per-digit glyphs ----------------
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        if (g == 0) begin : g_lsd
            assign w_blank[g] = 1'b0;
        end else begin : g_upper
            // Blank when this digit and everything above it is zero.
            assign w_blank[g] = r_disp_blz && (r_disp[NUM_DIGITS-1:g] == '0);
        end
        assign w_seg[g] = (r_ovf      ? SEG_DASH  :
                           w_blank[g] ? SEG_BLANK : hex2seg(r_disp[g]))
                          | {r_disp_dp[g], 7'd0};
    end

    // ---------------- scan ----------------
    always_comb begin
        w_wrap    = (r_pre == PRE_W'(SCAN_DIV - 1));
        w_idx_nxt = r_idx;
        if (w_wrap) begin
            w_idx_nxt = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // seg follows the next index so it and dig_en switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre    <= '0;
            r_idx    <= '0;
            r_seg    <= HEX_SEG[0];
            r_dig_en <= NUM_DIGITS'(1);
        end else begin
            r_pre    <= w_wrap ? '0 : r_pre + PRE_W'(1);
            r_idx    <= w_idx_nxt;
            r_seg    <= w_seg[w_idx_nxt];
            r_dig_en <= NUM_DIGITS'(1) << w_idx_nxt;
        end
    end

    assign seg      = r_seg;
    assign dig_en   = r_dig_en;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench: loads drive a scoreboard of expected full display frames,
// a monitor samples one complete scan cycle and compares per digit.
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
    localparam int DW = 16;
    localparam int SD = 4;

    logic          clk;
    logic          rst_n;
    logic [7:0]    seg;
    logic [ND-1:0] dig_en;
    logic          overflow;

    seven_seg_scan_driver_if #(.DATA_W(DW), .NUM_DIGITS(ND)) ld_if ();

    seven_seg_scan_driver #(
        .NUM_DIGITS (ND),
        .DATA_W     (DW),
        .SCAN_DIV   (SD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld_if),
        .seg      (seg),
        .dig_en   (dig_en),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [3:0][7:0] seg;
        logic            ovf;
    } frame_t;

    frame_t sb_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor: grabs one full scan period per queued frame.
    frame_t          m_exp;
    logic [3:0][7:0] m_got;
    logic [3:0]      m_seen;
    bit              m_bad;

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0 && rst_n) begin
                m_exp  = sb_q[0];
                m_got  = '0;
                m_seen = '0;
                m_bad  = 1'b0;
                for (int c = 0; c < ND * SD; c++) begin
                    if (!$onehot(dig_en)) m_bad = 1'b1;
                    for (int d = 0; d < ND; d++) begin
                        if (dig_en[d]) begin
                            m_got[d]  = seg;
                            m_seen[d] = 1'b1;
                        end
                    end
                    @(negedge clk);
                end
                check({m_exp.name, "_onehot"}, 32'(m_bad), 32'd0);
                check({m_exp.name, "_seen"}, 32'(m_seen), 32'hF);
                for (int d = 0; d < ND; d++)
                    check($sformatf("%s_d%0d", m_exp.name, d), 32'(m_got[d]), 32'(m_exp.seg[d]));
                check({m_exp.name, "_ovf"}, 32'(overflow), 32'(m_exp.ovf));
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic push_frame(input string name, input logic [7:0] d3, d2, d1, d0,
                              input logic ovf);
        frame_t f;
        int     k;
        f.name = name;
        f.seg  = {d3, d2, d1, d0};
        f.ovf  = ovf;
        sb_q.push_back(f);
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Issues one load; returns how many sampled cycles load_ready stayed low.
    task automatic do_load(input logic [DW-1:0] v, input logic dec, input logic blz,
                           input logic [ND-1:0] dp, input bit junk, output int low);
        int k;
        k = 0;
        while (!ld_if.load_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        ld_if.value      = v;
        ld_if.dec_mode   = dec;
        ld_if.blank_lz   = blz;
        ld_if.dp_in      = dp;
        ld_if.load_valid = 1'b1;
        @(posedge clk); #1;
        ld_if.load_valid = 1'b0;
        low = 0;
        while (!ld_if.load_ready && low < 100) begin
            low++;
            if (junk && low == 3) begin
                ld_if.value      = 16'h0009;
                ld_if.dec_mode   = 1'b0;
                ld_if.load_valid = 1'b1;
            end
            if (junk && low == 5) ld_if.load_valid = 1'b0;
            @(posedge clk); #1;
        end
        ld_if.load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    int lc;

    initial begin
        rst_n            = 1'b0;
        ld_if.load_valid = 1'b0;
        ld_if.value      = '0;
        ld_if.dec_mode   = 1'b0;
        ld_if.blank_lz   = 1'b0;
        ld_if.dp_in      = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_dig_en", 32'(dig_en), 32'h1);
        check("rst_seg", 32'(seg), 32'h3F);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_ready", 32'(ld_if.load_ready), 32'h1);

        repeat (3) @(posedge clk); #1;
        check("scan_hold", 32'(dig_en), 32'h1);
        @(posedge clk); #1;
        check("scan_step", 32'(dig_en), 32'h2);
        repeat (12) @(posedge clk); #1;
        check("scan_wrap", 32'(dig_en), 32'h1);

        // Digit 0 just became active: 4 cycles of it remain to watch the commit.
        ld_if.value      = 16'h0006;
        ld_if.dec_mode   = 1'b0;
        ld_if.blank_lz   = 1'b0;
        ld_if.dp_in      = '0;
        ld_if.load_valid = 1'b1;
        @(posedge clk); #1;
        ld_if.load_valid = 1'b0;
        check("hex_lat_t0", 32'(seg), 32'h3F);
        check("hex_ready_low", 32'(ld_if.load_ready), 32'h0);
        @(posedge clk); #1;
        check("hex_lat_t1", 32'(seg), 32'h3F);
        @(posedge clk); #1;
        check("hex_lat_t2", 32'(seg), 32'h7D);
        check("hex_lat_dig", 32'(dig_en), 32'h1);
        push_frame("hex6_nolz", 8'h3F, 8'h3F, 8'h3F, 8'h7D, 1'b0);

        do_load(16'h0006, 1'b0, 1'b1, 4'b0000, 1'b0, lc);
        check("hex_busy_cycles", 32'(lc), 32'd1);
        push_frame("hex6_lz", 8'h00, 8'h00, 8'h00, 8'h7D, 1'b0);

        do_load(16'd1234, 1'b1, 1'b1, 4'b0000, 1'b1, lc);
        check("dec_busy_cycles", 32'(lc), 32'd17);
        push_frame("dec1234", 8'h06, 8'h5B, 8'h4F, 8'h66, 1'b0);

        do_load(16'd9999, 1'b1, 1'b0, 4'b0000, 1'b0, lc);
        push_frame("dec9999", 8'h6F, 8'h6F, 8'h6F, 8'h6F, 1'b0);

        do_load(16'd10000, 1'b1, 1'b1, 4'b0000, 1'b0, lc);
        push_frame("dec10000", 8'h40, 8'h40, 8'h40, 8'h40, 1'b1);

        do_load(16'hBEEF, 1'b0, 1'b1, 4'b0000, 1'b0, lc);
        push_frame("hexBEEF", 8'h7C, 8'h79, 8'h79, 8'h71, 1'b0);

        do_load(16'h0000, 1'b0, 1'b1, 4'b0100, 1'b0, lc);
        push_frame("hex0_dp2", 8'h00, 8'h80, 8'h00, 8'h3F, 1'b0);

        do_load(16'd7, 1'b1, 1'b1, 4'b0000, 1'b0, lc);
        push_frame("dec7_lz", 8'h00, 8'h00, 8'h00, 8'h07, 1'b0);

        do_load(16'd10000, 1'b1, 1'b1, 4'b0001, 1'b0, lc);
        push_frame("dec10000_dp0", 8'h40, 8'h40, 8'h40, 8'hC0, 1'b1);

        // Reset in the middle of a conversion.
        ld_if.value      = 16'd4321;
        ld_if.dec_mode   = 1'b1;
        ld_if.blank_lz   = 1'b0;
        ld_if.dp_in      = '0;
        ld_if.load_valid = 1'b1;
        @(posedge clk); #1;
        ld_if.load_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("conv_busy", 32'(ld_if.load_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ld_if.load_ready), 32'h1);
        check("abort_dig_en", 32'(dig_en), 32'h1);
        check("abort_seg", 32'(seg), 32'h3F);
        check("abort_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_load(16'd4321, 1'b1, 1'b0, 4'b0000, 1'b0, lc);
        check("post_abort_busy", 32'(lc), 32'd17);
        push_frame("dec4321", 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
